// File: rtl/alu_pc_pkg.sv
// alu_pc_pkg: shared types and constants for alu_pc_unit.
//   aluop_e  - 5-bit ALU operation encoding
//   PC_W     - program counter width (12)
//   XLEN     - datapath width (32)
//   PC_RESET - PC value loaded on reset
`timescale 1ns/1ps
package alu_pc_pkg;

    localparam int PC_W = 12;
    localparam int XLEN = 32;

    localparam logic [PC_W-1:0] PC_RESET = 12'h000;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_SRL   = 5'd5,
        ALU_SRA   = 5'd6,
        ALU_OR    = 5'd7,
        ALU_AND   = 5'd8,
        ALU_PASSB = 5'd9,
        ALU_MUL   = 5'd10,
        ALU_MULH  = 5'd11
    } aluop_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV32I integer ALU.
//   aluop  in  5   operation select (see alu_pc_pkg::aluop_e)
//   sign   in  1   1 = signed SLT/MULH, 0 = unsigned
//   op1    in  32  first operand
//   op2    in  32  second operand (shift amount taken from op2[4:0])
//   result out 32  ALU result (0 for unused codes)
//   zero   out 1   result == 0
//   neg    out 1   result[31]
// Build option: define ALU_MUL_EN to enable MUL (10) and MULH (11);
// otherwise those codes behave like any other unused code.
`timescale 1ns/1ps
module alu_core
    import alu_pc_pkg::*;
(
    input  logic [4:0]      aluop,
    input  logic            sign,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            neg
);

    logic [4:0] shamt;
    logic       lt;

    assign shamt = op2[4:0];
    assign lt    = sign ? ($signed(op1) < $signed(op2)) : (op1 < op2);

`ifdef ALU_MUL_EN
    // Extend both operands to 64 bits according to sign; the low 64 bits of
    // the product of the extended operands are then correct for both
    // signed x signed and unsigned x unsigned.
    logic [2*XLEN-1:0] op1_x, op2_x, prod;

    assign op1_x = sign ? {{XLEN{op1[XLEN-1]}}, op1} : {{XLEN{1'b0}}, op1};
    assign op2_x = sign ? {{XLEN{op2[XLEN-1]}}, op2} : {{XLEN{1'b0}}, op2};
    assign prod  = op1_x * op2_x;
`endif

    always_comb begin
        result = '0;
        case (aluop)
            ALU_ADD:   result = op1 + op2;
            ALU_SUB:   result = op1 - op2;
            ALU_SLL:   result = op1 << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt};
            ALU_XOR:   result = op1 ^ op2;
            ALU_SRL:   result = op1 >> shamt;
            ALU_SRA:   result = $signed(op1) >>> shamt;
            ALU_OR:    result = op1 | op2;
            ALU_AND:   result = op1 & op2;
            ALU_PASSB: result = op2;
`ifdef ALU_MUL_EN
            ALU_MUL:   result = prod[XLEN-1:0];
            ALU_MULH:  result = prod[2*XLEN-1:XLEN];
`endif
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[XLEN-1];

endmodule

// File: rtl/alu_pc_unit.sv
// alu_pc_unit: execute-stage ALU plus fetch-stage PC register and +4 adders.
//   clk          in  1   rising-edge clock
//   rst          in  1   synchronous active-high reset (PC <- PC_RESET)
//   pc_write     in  1   PC load enable (low = stall)
//   pc_new       in  12  next PC value
//   pc           out 12  current PC (registered)
//   pc_plus4     out 12  pc + 4 (wraps)
//   pc_dec       in  12  decode-stage PC
//   pc_dec_plus4 out 12  pc_dec + 4 (wraps)
//   aluop, sign, op1, op2, result, zero, neg: combinational ALU, see alu_core
// Build option: ALU_MUL_EN enables the multiply opcodes inside alu_core.
`timescale 1ns/1ps
module alu_pc_unit
    import alu_pc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic [PC_W-1:0] pc_new,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    input  logic [PC_W-1:0] pc_dec,
    output logic [PC_W-1:0] pc_dec_plus4,
    input  logic [4:0]      aluop,
    input  logic            sign,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            neg
);

    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (pc_write) pc_d = pc_new;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= PC_RESET;
        else     pc_q <= pc_d;
    end

    assign pc           = pc_q;
    // Both adders drop the carry out of bit 11, so 0xFFC + 4 wraps to 0.
    assign pc_plus4     = pc_q + PC_W'(4);
    assign pc_dec_plus4 = pc_dec + PC_W'(4);

    alu_core u_alu (
        .aluop  (aluop),
        .sign   (sign),
        .op1    (op1),
        .op2    (op2),
        .result (result),
        .zero   (zero),
        .neg    (neg)
    );

endmodule

// File: tb/tb_alu_pc_unit.sv
`timescale 1ns/1ps
module tb_alu_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write = 1'b0;
    logic [11:0] pc_new = '0;
    logic [11:0] pc;
    logic [11:0] pc_plus4;
    logic [11:0] pc_dec = '0;
    logic [11:0] pc_dec_plus4;
    logic [4:0]  aluop = '0;
    logic        sign = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [31:0] result;
    logic        zero;
    logic        neg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc_write     (pc_write),
        .pc_new       (pc_new),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .pc_dec       (pc_dec),
        .pc_dec_plus4 (pc_dec_plus4),
        .aluop        (aluop),
        .sign         (sign),
        .op1          (op1),
        .op2          (op2),
        .result       (result),
        .zero         (zero),
        .neg          (neg)
    );

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_write = 1'b1; pc_new = 12'h123;
        tick();
        checks++;
        if (pc !== 12'h000) begin
            failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 12'h000);
        end
        checks++;
        if (pc_plus4 !== 12'h004) begin
            failures++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 12'h004);
        end
    endtask

    task automatic test_load_stall();
        rst = 1'b0; pc_write = 1'b1; pc_new = 12'h010;
        tick();
        checks++;
        if (pc !== 12'h010) begin
            failures++; $display("FAIL load_pc got=%h exp=%h", pc, 12'h010);
        end
        pc_write = 1'b0; pc_new = 12'h020;
        #2 pc_new = 12'h030;   // wiggle while stalled
        tick();
        checks++;
        if (pc !== 12'h010) begin
            failures++; $display("FAIL stall_pc got=%h exp=%h", pc, 12'h010);
        end
        // rst pulse between edges must not disturb the register
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        checks++;
        if (pc !== 12'h010) begin
            failures++; $display("FAIL rst_glitch_pc got=%h exp=%h", pc, 12'h010);
        end
        // reset wins over a simultaneous write
        rst = 1'b1; pc_write = 1'b1; pc_new = 12'h555;
        tick();
        checks++;
        if (pc !== 12'h000) begin
            failures++; $display("FAIL rst_priority_pc got=%h exp=%h", pc, 12'h000);
        end
        rst = 1'b0; pc_write = 1'b0;
    endtask

    task automatic test_wrap();
        pc_dec = 12'hFFC;
        #1;
        checks++;
        if (pc_dec_plus4 !== 12'h000) begin
            failures++; $display("FAIL dec_wrap got=%h exp=%h", pc_dec_plus4, 12'h000);
        end
        pc_dec = 12'h123;
        #1;
        checks++;
        if (pc_dec_plus4 !== 12'h127) begin
            failures++; $display("FAIL dec_plus4 got=%h exp=%h", pc_dec_plus4, 12'h127);
        end
        pc_write = 1'b1; pc_new = 12'hFFC;
        tick();
        pc_write = 1'b0;
        checks++;
        if (pc !== 12'hFFC || pc_plus4 !== 12'h000) begin
            failures++; $display("FAIL pc_wrap got=%h/%h exp=ffc/000", pc, pc_plus4);
        end
    endtask

    // Shared table walker: op, sign, op1, op2 -> result, zero, neg
    task automatic test_arith();
        logic [4:0]  t_op [3] = '{5'd1, 5'd1, 5'd0};
        logic [31:0] t_a  [3] = '{32'd5, 32'd3, 32'hFFFF_FFFF};
        logic [31:0] t_b  [3] = '{32'd5, 32'd5, 32'd1};
        logic [31:0] t_r  [3] = '{32'd0, 32'hFFFF_FFFE, 32'd0};
        logic        t_z  [3] = '{1'b1, 1'b0, 1'b1};
        logic        t_n  [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            aluop = t_op[i]; sign = 1'b0; op1 = t_a[i]; op2 = t_b[i];
            #1;
            checks++;
            if (result !== t_r[i] || zero !== t_z[i] || neg !== t_n[i]) begin
                failures++;
                $display("FAIL arith[%0d] got=%h z=%b n=%b exp=%h z=%b n=%b",
                         i, result, zero, neg, t_r[i], t_z[i], t_n[i]);
            end
        end
    endtask

    task automatic test_cmp_shift();
        logic [4:0]  t_op [5] = '{5'd3, 5'd3, 5'd6, 5'd5, 5'd2};
        logic        t_s  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h8000_0000, 32'h0000_0003};
        logic [31:0] t_b  [5] = '{32'd1, 32'd1, 32'h21, 32'h21, 32'h24};
        logic [31:0] t_r  [5] = '{32'd1, 32'd0, 32'hC000_0000, 32'h4000_0000,
                                  32'h0000_0030};
        for (int i = 0; i < 5; i++) begin
            aluop = t_op[i]; sign = t_s[i]; op1 = t_a[i]; op2 = t_b[i];
            #1;
            checks++;
            if (result !== t_r[i] || zero !== (t_r[i] == 0) || neg !== t_r[i][31]) begin
                failures++;
                $display("FAIL cmp_shift[%0d] got=%h z=%b n=%b exp=%h", i, result, zero, neg, t_r[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [4:0]  t_op [5] = '{5'd8, 5'd7, 5'd4, 5'd9, 5'd31};
        logic [31:0] t_r  [5] = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00,
                                  32'h0FF0_0FF0, 32'h0000_0000};
        logic        t_z  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        t_n  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        op1 = 32'hF0F0_F0F0; op2 = 32'h0FF0_0FF0; sign = 1'b1;
        for (int i = 0; i < 5; i++) begin
            aluop = t_op[i];
            #1;
            checks++;
            if (result !== t_r[i] || zero !== t_z[i] || neg !== t_n[i]) begin
                failures++;
                $display("FAIL logic[%0d] got=%h z=%b n=%b exp=%h z=%b n=%b",
                         i, result, zero, neg, t_r[i], t_z[i], t_n[i]);
            end
        end
    endtask

    task automatic test_mul();
        op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
`ifdef ALU_MUL_EN
        aluop = 5'd11; sign = 1'b1;
        #1;
        checks++;
        if (result !== 32'h0000_0000 || zero !== 1'b1) begin
            failures++; $display("FAIL mulh_signed got=%h exp=00000000", result);
        end
        sign = 1'b0;
        #1;
        checks++;
        if (result !== 32'hFFFF_FFFE || neg !== 1'b1) begin
            failures++; $display("FAIL mulh_unsigned got=%h exp=fffffffe", result);
        end
        aluop = 5'd10;
        #1;
        checks++;
        if (result !== 32'h0000_0001) begin
            failures++; $display("FAIL mul_low got=%h exp=00000001", result);
        end
`else
        aluop = 5'd10; sign = 1'b1;
        #1;
        checks++;
        if (result !== 32'h0 || zero !== 1'b1 || neg !== 1'b0) begin
            failures++; $display("FAIL mul_disabled got=%h z=%b exp=00000000 z=1", result, zero);
        end
        aluop = 5'd11;
        #1;
        checks++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            failures++; $display("FAIL mulh_disabled got=%h z=%b exp=00000000 z=1", result, zero);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_stall();
        test_wrap();
        test_arith();
        test_cmp_shift();
        test_logic();
        test_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
